// File: rtl/commit_trace_tx_if.sv
// Commit-trace bundle: retirement events from writeback, plus the outgoing
// trace stream and its status flags.
interface commit_trace_tx_if;
  logic        regWrEn;
  logic [2:0]  writeRegSel;
  logic [15:0] writeData;
  logic        memRdEn;
  logic        memWrEn;
  logic [15:0] memAddr;
  logic [15:0] memDataIn;
  logic [15:0] memDataOut;
  logic        halt;
  logic        trace_valid;
  logic        trace_ready;
  logic [1:0]  trace_kind;
  logic [15:0] trace_addr;
  logic [15:0] trace_data;
  logic [31:0] trace_cycle;
  logic        stall;
  logic        overflow;
  logic        done;

  modport master (
    input  regWrEn, writeRegSel, writeData, memRdEn, memWrEn,
    input  memAddr, memDataIn, memDataOut, halt, trace_ready,
    output trace_valid, trace_kind, trace_addr, trace_data, trace_cycle,
    output stall, overflow, done
  );

  modport slave (
    output regWrEn, writeRegSel, writeData, memRdEn, memWrEn,
    output memAddr, memDataIn, memDataOut, halt, trace_ready,
    input  trace_valid, trace_kind, trace_addr, trace_data, trace_cycle,
    input  stall, overflow, done
  );
endinterface

// File: rtl/commit_trace_tx.sv
// Commit-trace transmitter: buffers per-cycle retirement events in a small
// FIFO and replays each entry as one typed beat per set flag
// (REG, LOAD, STORE, HALT) over a valid/ready stream.
module commit_trace_tx #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input logic clk,
  input logic rst,
  commit_trace_tx_if.master bus
);

  typedef enum logic [1:0] {
    KindReg   = 2'd0,
    KindLoad  = 2'd1,
    KindStore = 2'd2,
    KindHalt  = 2'd3
  } kind_e;

  localparam logic [PTR_W:0]   DepthC    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   NearFullC = (PTR_W+1)'(DEPTH - 1);
  localparam logic [PTR_W:0]   CountOneC = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PtrOneC   = PTR_W'(1);

  // Entry storage; flag bit order is {halt, store, load, reg}
  logic [3:0]  flagsMem [DEPTH];
  logic [2:0]  selMem   [DEPTH];
  logic [15:0] wdMem    [DEPTH];
  logic [15:0] addrMem  [DEPTH];
  logic [15:0] dinMem   [DEPTH];
  logic [15:0] doutMem  [DEPTH];
  logic [31:0] cycMem   [DEPTH];

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [31:0]      cycle_q, cycle_d;
  logic [15:0]      instCount_q, instCount_d;
  logic [3:0]       sent_q, sent_d;
  logic             halted_q, halted_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;

  logic       anyEvent, full, push, pop, fire, valid, lastBeat, counts;
  logic [3:0] headFlags, remFlags, curBit;
  kind_e      curKind;

  assign anyEvent  = (bus.regWrEn | bus.memRdEn | bus.memWrEn | bus.halt) & ~halted_q;
  assign full      = (count_q == DepthC);
  assign push      = anyEvent & ~full;
  assign counts    = bus.regWrEn | bus.memWrEn | bus.halt;
  assign valid     = (count_q != '0);
  assign headFlags = flagsMem[rdPtr_q];
  assign remFlags  = headFlags & ~sent_q;
  assign fire      = valid & bus.trace_ready;
  assign lastBeat  = ((remFlags & ~curBit) == 4'b0000);
  assign pop       = fire & lastBeat;

  // Pick the lowest outstanding flag of the head entry as the current beat
  always_comb begin
    curBit  = 4'b0000;
    curKind = KindReg;
    if (remFlags[0]) begin
      curBit  = 4'b0001;
      curKind = KindReg;
    end else if (remFlags[1]) begin
      curBit  = 4'b0010;
      curKind = KindLoad;
    end else if (remFlags[2]) begin
      curBit  = 4'b0100;
      curKind = KindStore;
    end else if (remFlags[3]) begin
      curBit  = 4'b1000;
      curKind = KindHalt;
    end
  end

  // Format the current beat; everything reads zero while the stream is idle
  always_comb begin
    bus.trace_valid = valid;
    bus.trace_kind  = 2'd0;
    bus.trace_addr  = 16'h0000;
    bus.trace_data  = 16'h0000;
    bus.trace_cycle = 32'h0;
    if (valid) begin
      bus.trace_kind  = curKind;
      bus.trace_cycle = cycMem[rdPtr_q];
      case (curKind)
        KindReg: begin
          bus.trace_addr = {13'b0, selMem[rdPtr_q]};
          bus.trace_data = wdMem[rdPtr_q];
        end
        KindLoad: begin
          bus.trace_addr = addrMem[rdPtr_q];
          bus.trace_data = doutMem[rdPtr_q];
        end
        KindStore: begin
          bus.trace_addr = addrMem[rdPtr_q];
          bus.trace_data = dinMem[rdPtr_q];
        end
        default: begin
          bus.trace_addr = instCount_q;
          bus.trace_data = cycMem[rdPtr_q][15:0];
        end
      endcase
    end
  end

  assign bus.stall    = (count_q >= NearFullC) | halted_q;
  assign bus.overflow = overflow_q;
  assign bus.done     = done_q;

  // Capture an accepted event into the slot at the write pointer
  always_ff @(posedge clk) begin
    if (push) begin
      flagsMem[wrPtr_q] <= {bus.halt, bus.memWrEn, bus.memRdEn, bus.regWrEn};
      selMem[wrPtr_q]   <= bus.writeRegSel;
      wdMem[wrPtr_q]    <= bus.writeData;
      addrMem[wrPtr_q]  <= bus.memAddr;
      dinMem[wrPtr_q]   <= bus.memDataIn;
      doutMem[wrPtr_q]  <= bus.memDataOut;
      cycMem[wrPtr_q]   <= cycle_q;
    end
  end

  // Next-state for pointers, occupancy, counters and sticky status
  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    cycle_d     = cycle_q + 32'd1;
    instCount_d = instCount_q;
    sent_d      = sent_q;
    halted_d    = halted_q;
    overflow_d  = overflow_q;
    done_d      = done_q;
    if (push) begin
      wrPtr_d = wrPtr_q + PtrOneC;
      if (counts) instCount_d = instCount_q + 16'd1;
      if (bus.halt) halted_d = 1'b1;
    end
    if (anyEvent & full) overflow_d = 1'b1;
    if (pop) begin
      rdPtr_d = rdPtr_q + PtrOneC;
      sent_d  = 4'b0000;
    end else if (fire) begin
      sent_d = sent_q | curBit;
    end
    if (fire & curBit[3]) done_d = 1'b1;
    if (push & ~pop) count_d = count_q + CountOneC;
    else if (pop & ~push) count_d = count_q - CountOneC;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      cycle_q     <= 32'h0;
      instCount_q <= 16'h0;
      sent_q      <= 4'b0000;
      halted_q    <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      cycle_q     <= cycle_d;
      instCount_q <= instCount_d;
      sent_q      <= sent_d;
      halted_q    <= halted_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_commit_trace_tx.sv
// Bench for commit_trace_tx: a queue-of-beats reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_commit_trace_tx;
  localparam int DEPTH = 8;

  logic clk;
  logic rst;
  commit_trace_tx_if bus();

  commit_trace_tx #(.DEPTH(DEPTH), .PTR_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [15:0] data;
    logic [31:0] cyc;
    bit          last;
  } beat_t;

  beat_t       mBeats[$];
  beat_t       newBeats[$];
  beat_t       nb;
  beat_t       ob;
  int          mEntries;
  logic [31:0] mCyc;
  logic [15:0] mInst;
  bit          mHalted, mOvf, mDone, armed;
  bit          hadValid, ev;
  int          passCount, totalCount;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record one comparison; mismatches print a FAIL line
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else
      passCount++;
  endtask

  task automatic setInputs(input logic rw, input logic [2:0] sel, input logic [15:0] wd,
                           input logic mr, input logic mw, input logic [15:0] addr,
                           input logic [15:0] din, input logic [15:0] dout, input logic h);
    bus.regWrEn     = rw;
    bus.writeRegSel = sel;
    bus.writeData   = wd;
    bus.memRdEn     = mr;
    bus.memWrEn     = mw;
    bus.memAddr     = addr;
    bus.memDataIn   = din;
    bus.memDataOut  = dout;
    bus.halt        = h;
  endtask

  // Hold one cycle's worth of commit inputs, starting at the next falling edge
  task automatic applyStimulus(input logic rw, input logic [2:0] sel, input logic [15:0] wd,
                               input logic mr, input logic mw, input logic [15:0] addr,
                               input logic [15:0] din, input logic [15:0] dout, input logic h);
    @(negedge clk);
    setInputs(rw, sel, wd, mr, mw, addr, din, dout, h);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
  endtask

  // One reset edge; returns in the first cycle after reset (cycle stamp 0)
  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    setInputs(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Reference model: FIFO of entries expanded into beats, advanced per clock
  always @(posedge clk) begin
    if (rst === 1'b0) begin
      mBeats.delete();
      mEntries = 0;
      mCyc     = 32'h0;
      mInst    = 16'h0;
      mHalted  = 1'b0;
      mOvf     = 1'b0;
      mDone    = 1'b0;
      armed    = 1'b1;
    end else if (armed) begin
      hadValid = (mBeats.size() > 0);
      ev = (bus.regWrEn | bus.memRdEn | bus.memWrEn | bus.halt) && !mHalted;
      if (ev) begin
        if (mEntries >= DEPTH) begin
          mOvf = 1'b1;
        end else begin
          if (bus.regWrEn | bus.memWrEn | bus.halt) mInst = mInst + 16'd1;
          newBeats.delete();
          if (bus.regWrEn) begin
            nb = '{2'd0, {13'b0, bus.writeRegSel}, bus.writeData, mCyc, 1'b0};
            newBeats.push_back(nb);
          end
          if (bus.memRdEn) begin
            nb = '{2'd1, bus.memAddr, bus.memDataOut, mCyc, 1'b0};
            newBeats.push_back(nb);
          end
          if (bus.memWrEn) begin
            nb = '{2'd2, bus.memAddr, bus.memDataIn, mCyc, 1'b0};
            newBeats.push_back(nb);
          end
          if (bus.halt) begin
            nb = '{2'd3, mInst, mCyc[15:0], mCyc, 1'b0};
            newBeats.push_back(nb);
            mHalted = 1'b1;
          end
          newBeats[newBeats.size()-1].last = 1'b1;
          foreach (newBeats[k]) mBeats.push_back(newBeats[k]);
          mEntries++;
        end
      end
      if (hadValid && bus.trace_ready) begin
        ob = mBeats.pop_front();
        if (ob.last) mEntries--;
        if (ob.kind == 2'd3) mDone = 1'b1;
      end
      mCyc = mCyc + 32'd1;
    end
  end

  // Compare DUT outputs against the model every cycle, away from the clock edge
  always @(negedge clk) begin
    if (armed) begin
      checkOutput("valid", 32'(bus.trace_valid), 32'(mBeats.size() > 0));
      checkOutput("stall", 32'(bus.stall), 32'((mEntries >= DEPTH-1) || mHalted));
      checkOutput("overflow", 32'(bus.overflow), 32'(mOvf));
      checkOutput("done", 32'(bus.done), 32'(mDone));
      if (mBeats.size() > 0) begin
        checkOutput("kind", 32'(bus.trace_kind), 32'(mBeats[0].kind));
        checkOutput("addr", 32'(bus.trace_addr), 32'(mBeats[0].addr));
        checkOutput("data", 32'(bus.trace_data), 32'(mBeats[0].data));
        checkOutput("cycle", bus.trace_cycle, mBeats[0].cyc);
      end
    end
  end

  initial begin
    passCount  = 0;
    totalCount = 0;
    armed      = 1'b0;
    rst        = 1'b0;
    bus.trace_ready = 1'b1;
    setInputs(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);

    // Reset state, then a single REG commit in cycle 2
    doReset();
    checkOutput("rst_valid", 32'(bus.trace_valid), 32'd0);
    checkOutput("rst_stall", 32'(bus.stall), 32'd0);
    checkOutput("rst_overflow", 32'(bus.overflow), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    idle();
    applyStimulus(1'b1, 3'd3, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    idle();
    checkOutput("reg_valid", 32'(bus.trace_valid), 32'd1);
    checkOutput("reg_kind", 32'(bus.trace_kind), 32'd0);
    checkOutput("reg_addr", 32'(bus.trace_addr), 32'h0003);
    checkOutput("reg_data", 32'(bus.trace_data), 32'h1234);
    checkOutput("reg_cycle", bus.trace_cycle, 32'd2);
    idle();
    checkOutput("reg_after_valid", 32'(bus.trace_valid), 32'd0);

    // Register write plus load in one cycle gives two beats; halt then shows count 3
    applyStimulus(1'b1, 3'd5, 16'hBEEF, 1'b1, 1'b0, 16'h00A0, 16'h0, 16'hBEEF, 1'b0);
    idle();
    checkOutput("rl_kind0", 32'(bus.trace_kind), 32'd0);
    checkOutput("rl_addr0", 32'(bus.trace_addr), 32'h0005);
    checkOutput("rl_data0", 32'(bus.trace_data), 32'hBEEF);
    idle();
    checkOutput("rl_kind1", 32'(bus.trace_kind), 32'd1);
    checkOutput("rl_addr1", 32'(bus.trace_addr), 32'h00A0);
    checkOutput("rl_data1", 32'(bus.trace_data), 32'hBEEF);
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    idle();
    checkOutput("h1_kind", 32'(bus.trace_kind), 32'd3);
    checkOutput("h1_addr", 32'(bus.trace_addr), 32'd3);
    checkOutput("h1_done_pre", 32'(bus.done), 32'd0);
    idle();
    checkOutput("h1_done", 32'(bus.done), 32'd1);
    applyStimulus(1'b1, 3'd1, 16'h7777, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    idle();
    checkOutput("h1_ignored", 32'(bus.trace_valid), 32'd0);
    checkOutput("h1_stall", 32'(bus.stall), 32'd1);

    // Nine stores into a blocked sink: stall at seven, ninth dropped
    doReset();
    bus.trace_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 16'(i), 16'(256 + i), 16'h0, 1'b0);
      if (i == 7) checkOutput("fill_stall6", 32'(bus.stall), 32'd0);
      if (i == 8) checkOutput("fill_stall7", 32'(bus.stall), 32'd1);
    end
    idle();
    checkOutput("fill_overflow", 32'(bus.overflow), 32'd1);
    bus.trace_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) idle();
      checkOutput("drain_kind", 32'(bus.trace_kind), 32'd2);
      checkOutput("drain_addr", 32'(bus.trace_addr), 32'(i));
      checkOutput("drain_data", 32'(bus.trace_data), 32'(256 + i));
    end
    idle();
    checkOutput("drain_empty", 32'(bus.trace_valid), 32'd0);

    // Store then halt two cycles later
    doReset();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 16'h0010, 16'h0055, 16'h0, 1'b0);
    idle();
    checkOutput("sh_kind", 32'(bus.trace_kind), 32'd2);
    checkOutput("sh_addr", 32'(bus.trace_addr), 32'h0010);
    checkOutput("sh_data", 32'(bus.trace_data), 32'h0055);
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    idle();
    checkOutput("sh_hkind", 32'(bus.trace_kind), 32'd3);
    checkOutput("sh_haddr", 32'(bus.trace_addr), 32'h0002);
    checkOutput("sh_hdata", 32'(bus.trace_data), 32'd3);
    idle();
    checkOutput("sh_done", 32'(bus.done), 32'd1);
    checkOutput("sh_valid", 32'(bus.trace_valid), 32'd0);

    // Reset in the middle of a two-beat entry with a backlog behind it
    doReset();
    bus.trace_ready = 1'b0;
    applyStimulus(1'b1, 3'd2, 16'hAAAA, 1'b1, 1'b0, 16'h0300, 16'h0, 16'hCCCC, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 16'(i), 16'(i), 16'h0, 1'b0);
    idle();
    bus.trace_ready = 1'b1;
    idle();
    bus.trace_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_valid", 32'(bus.trace_valid), 32'd0);
    checkOutput("mid_stall", 32'(bus.stall), 32'd0);
    checkOutput("mid_done", 32'(bus.done), 32'd0);
    rst = 1'b1;
    setInputs(1'b1, 3'd6, 16'h0BAD, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    idle();
    checkOutput("mid_new_kind", 32'(bus.trace_kind), 32'd0);
    checkOutput("mid_new_cycle", bus.trace_cycle, 32'd0);
    bus.trace_ready = 1'b1;

    // Twenty REG events while ready toggles; pointers wrap twice
    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 3'(i), 16'(16'h0200 + i), 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
      bus.trace_ready = ~bus.trace_ready;
      idle();
      bus.trace_ready = ~bus.trace_ready;
    end
    bus.trace_ready = 1'b1;
    repeat (12) idle();
    checkOutput("wrap_overflow", 32'(bus.overflow), 32'd0);
    checkOutput("wrap_empty", 32'(bus.trace_valid), 32'd0);

    // Random traffic with occasional resets and halts
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) != 0);
      bus.trace_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 4) begin
        setInputs(1'($urandom), 3'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                  16'($urandom), 16'($urandom), 16'($urandom),
                  ($urandom_range(0, 39) == 0));
      end else begin
        setInputs(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    bus.trace_ready = 1'b1;
    setInputs(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
